// File: rtl/fifo_bank_seq.sv
// Fill/drain sequencer for a bank of DIM systolic delay fifos. A per-fifo head
// shadow lets an abort walk every fifo head back to slot 0 without a reset.
module fifo_bank_seq #(
  parameter int DIM  = 8,
  parameter int BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                wr_valid,
  input  logic [DIM*BITS-1:0] wr_data,
  output logic                wr_ready,
  input  logic                drain_stall,
  output logic [DIM-1:0]      fifo_en,
  output logic [DIM*BITS-1:0] fifo_d,
  output logic [DIM-1:0]      q_valid,
  output logic                busy,
  output logic                done
);

  localparam int FW = $clog2(DIM);
  localparam int DW = $clog2(2 * DIM);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [FW-1:0]   fc_r;
  logic [FW-1:0]   fc_s;
  logic [DW-1:0]   dc_r;
  logic [DW-1:0]   dc_s;
  logic [FW-1:0]   hcnt_r [DIM];
  logic            done_r;
  logic            done_s;
  logic [DIM-1:0]  live_s;
  logic [DIM-1:0]  flush_en_s;

  // Diagonal wavefront: fifo i is live for drain steps i .. i+DIM-1.
  always_comb begin
    live_s = {DIM{1'b0}};
    for (int i = 0; i < DIM; i++) begin
      live_s[i] = ({1'b0, dc_r} >= (DW+1)'(i)) && ({1'b0, dc_r} < (DW+1)'(i + DIM));
    end
  end

  // Fifos whose head shadow is off slot 0 still need shifting during a flush.
  always_comb begin
    flush_en_s = {DIM{1'b0}};
    for (int i = 0; i < DIM; i++) begin
      flush_en_s[i] = (hcnt_r[i] != {FW{1'b0}});
    end
  end

  // Next-state, counter and fifo-control decode.
  always_comb begin
    state_s  = state_r;
    fc_s     = fc_r;
    dc_s     = dc_r;
    done_s   = 1'b0;
    wr_ready = 1'b0;
    fifo_en  = {DIM{1'b0}};
    fifo_d   = {(DIM*BITS){1'b0}};
    q_valid  = {DIM{1'b0}};
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = FILL;
          fc_s    = {FW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (abort) begin
          state_s = FLUSH;
        end else begin
          wr_ready = 1'b1;
          if (wr_valid) begin
            fifo_en = {DIM{1'b1}};
            fifo_d  = wr_data;
            fc_s    = fc_r + FW'(1);
            if (fc_r == {FW{1'b1}}) begin
              state_s = DRAIN;
              dc_s    = {DW{1'b0}};
            end else begin
              state_s = FILL;
            end
          end else begin
            fifo_en = {DIM{1'b0}};
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_s = FLUSH;
        end else if (!drain_stall) begin
          fifo_en = live_s;
          q_valid = live_s;
          dc_s    = dc_r + DW'(1);
          if (dc_r == DW'(2 * DIM - 2)) begin
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            state_s = DRAIN;
          end
        end else begin
          dc_s = dc_r;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      FLUSH: begin
        fifo_en = flush_en_s;
        if (flush_en_s == {DIM{1'b0}}) begin
          state_s = IDLE;
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer state, counters and the registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      fc_r    <= {FW{1'b0}};
      dc_r    <= {DW{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      fc_r    <= fc_s;
      dc_r    <= dc_s;
      done_r  <= done_s;
    end
  end

  // Head shadows track every shift of their fifo, wrapping naturally mod DIM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++) begin
        hcnt_r[i] <= {FW{1'b0}};
      end
    end else begin
      for (int i = 0; i < DIM; i++) begin
        if (fifo_en[i]) begin
          hcnt_r[i] <= hcnt_r[i] + FW'(1);
        end else begin
          hcnt_r[i] <= hcnt_r[i];
        end
      end
    end
  end

  assign busy = (state_r != IDLE);
  assign done = done_r;

endmodule

// File: tb/tb_fifo_bank_seq.sv
// Directed and randomized bench for fifo_bank_seq (DIM=4, BITS=8) with a
// small fifo bank driven by the DUT and a phase-level reference model.
module tb_fifo_bank_seq;

  localparam int DIM  = 4;
  localparam int BITS = 8;
  localparam int W    = DIM * BITS;

  localparam int P_IDLE  = 0;
  localparam int P_FILL  = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;
  localparam int P_FLUSH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           wr_valid = 1'b0;
  logic [W-1:0]   wr_data = '0;
  logic           drain_stall = 1'b0;
  logic           wr_ready;
  logic [DIM-1:0] fifo_en;
  logic [W-1:0]   fifo_d;
  logic [DIM-1:0] q_valid;
  logic           busy;
  logic           done;

  int checks = 0;
  int failures = 0;

  // reference model
  int             phase;
  int             nw;
  int             k;
  int             heads [DIM];
  logic [W-1:0]   vec [DIM];
  logic [DIM-1:0] last_en;

  // fifo bank fed by the DUT
  logic [BITS-1:0] fmem [DIM][DIM];
  int              fptr [DIM];

  always #5 clk = ~clk;

  fifo_bank_seq #(.DIM(DIM), .BITS(BITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .drain_stall(drain_stall), .fifo_en(fifo_en), .fifo_d(fifo_d),
    .q_valid(q_valid), .busy(busy), .done(done)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++) begin
        fptr[i] <= 0;
        for (int j = 0; j < DIM; j++) fmem[i][j] <= '0;
      end
    end else begin
      for (int i = 0; i < DIM; i++) begin
        if (fifo_en[i]) begin
          fmem[i][fptr[i]] <= fifo_d[i*BITS +: BITS];
          fptr[i] <= (fptr[i] + 1) % DIM;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    phase = P_IDLE;
    nw = 0;
    k = 0;
    for (int i = 0; i < DIM; i++) heads[i] = 0;
  endtask

  task automatic step(input bit st, input bit ab, input bit wv,
                      input logic [W-1:0] wd, input bit stl);
    logic [DIM-1:0] een;
    logic [DIM-1:0] eqv;
    logic [W-1:0]   ed;
    bit             erdy;
    start = st; abort = ab; wr_valid = wv; wr_data = wd; drain_stall = stl;
    #1;
    een = '0; eqv = '0; ed = '0; erdy = 1'b0;
    case (phase)
      P_FILL: if (!ab) begin
        erdy = 1'b1;
        if (wv) begin een = '1; ed = wd; end
      end
      P_DRAIN: if (!ab && !stl) begin
        for (int i = 0; i < DIM; i++) if (k >= i && k < i + DIM) een[i] = 1'b1;
        eqv = een;
      end
      P_FLUSH: for (int i = 0; i < DIM; i++) een[i] = (heads[i] != 0);
      default: ;
    endcase
    chk("wr_ready", 64'(wr_ready), 64'(erdy));
    chk("fifo_en", 64'(fifo_en), 64'(een));
    chk("fifo_d", 64'(fifo_d), 64'(ed));
    chk("q_valid", 64'(q_valid), 64'(eqv));
    chk("busy", 64'(busy), 64'(phase != P_IDLE));
    chk("done", 64'(done), 64'(phase == P_DONE));
    for (int i = 0; i < DIM; i++) begin
      if (eqv[i]) chk("fifo_q", 64'(fmem[i][fptr[i]]), 64'(vec[k-i][i*BITS +: BITS]));
    end
    last_en = fifo_en;
    @(posedge clk);
    for (int i = 0; i < DIM; i++) heads[i] = (heads[i] + int'(een[i])) % DIM;
    case (phase)
      P_IDLE: if (st) begin phase = P_FILL; nw = 0; end
      P_FILL: begin
        if (ab) phase = P_FLUSH;
        else if (wv) begin
          vec[nw] = wd;
          nw++;
          if (nw == DIM) begin phase = P_DRAIN; k = 0; end
        end
      end
      P_DRAIN: begin
        if (ab) phase = P_FLUSH;
        else if (!stl) begin
          k++;
          if (k == 2 * DIM - 1) phase = P_DONE;
        end
      end
      P_DONE: phase = P_IDLE;
      P_FLUSH: if (een == '0) phase = P_IDLE;
      default: phase = P_IDLE;
    endcase
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic heads_at_zero();
    for (int i = 0; i < DIM; i++) chk("head_realign", 64'(fptr[i]), 64'(0));
  endtask

  initial begin
    logic [W-1:0]   base [DIM];
    logic [DIM-1:0] seq [2*DIM-1];
    base[0] = 32'h04030201; base[1] = 32'h08070605;
    base[2] = 32'h0C0B0A09; base[3] = 32'h100F0E0D;
    seq[0] = 4'h1; seq[1] = 4'h3; seq[2] = 4'h7; seq[3] = 4'hF;
    seq[4] = 4'hE; seq[5] = 4'hC; seq[6] = 4'h8;
    model_reset();

    // reset state
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_en", 64'(fifo_en), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ready", 64'(wr_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle_step();

    // full back-to-back run
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int j = 0; j < DIM; j++) step(1'b0, 1'b0, 1'b1, base[j], 1'b0);
    for (int j = 0; j < 2*DIM-1; j++) begin
      idle_step();
      chk("drain_seq", 64'(last_en), 64'(seq[j]));
    end
    idle_step();
    idle_step();

    // bubbles on alternate cycles
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int j = 0; j < 2*DIM; j++) step(1'b0, 1'b0, 1'(j % 2), W'($urandom), 1'b0);
    for (int j = 0; j < 2*DIM; j++) idle_step();
    idle_step();

    // stall after second drain cycle
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int j = 0; j < DIM; j++) step(1'b0, 1'b0, 1'b1, W'($urandom), 1'b0);
    idle_step(); idle_step();
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int j = 0; j < 2*DIM-3; j++) begin
      idle_step();
      chk("stall_resume", 64'(last_en), 64'(seq[j+2]));
    end
    idle_step();
    idle_step();

    // abort after two writes, then a full run
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int j = 0; j < 2; j++) step(1'b0, 1'b0, 1'b1, W'($urandom), 1'b0);
    step(1'b0, 1'b1, 1'b1, W'($urandom), 1'b0);
    for (int j = 0; j < 3; j++) idle_step();
    heads_at_zero();
    idle_step();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int j = 0; j < DIM; j++) step(1'b0, 1'b0, 1'b1, base[j], 1'b0);
    for (int j = 0; j < 2*DIM-1; j++) begin
      idle_step();
      chk("rerun_seq", 64'(last_en), 64'(seq[j]));
    end
    idle_step();
    idle_step();

    // abort at dc=2
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int j = 0; j < DIM; j++) step(1'b0, 1'b0, 1'b1, W'($urandom), 1'b0);
    idle_step(); idle_step();
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int j = 0; j < 4; j++) idle_step();
    heads_at_zero();
    idle_step();

    // reset mid-DRAIN
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int j = 0; j < DIM; j++) step(1'b0, 1'b0, 1'b1, W'($urandom), 1'b0);
    idle_step(); idle_step(); idle_step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_en", 64'(fifo_en), 64'(0));
    chk("mid_rst_qv", 64'(q_valid), 64'(0));
    chk("mid_rst_d", 64'(fifo_d), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_step();

    // randomized traffic
    for (int j = 0; j < 400; j++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 2) != 0), W'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
